// File: rtl/cmd_queue_irq_coalesce.sv
// rtl/cmd_queue_irq_coalesce.sv - per-source interrupt coalescer with req/ack output
//
// Purpose: counts rising edges of irq_sq / irq_cq, fires a source once its pending
// count reaches cfg_thresh (0 acts as 1) or its timer reaches cfg_timeout (0 = off),
// and presents one request at a time to the interrupt controller on irq_req/irq_ack.
// When both sources fire together the grant alternates against the last granted source.
//
// Ports:
//   aclk, aresetn           clock, asynchronous active-low reset
//   irq_sq, irq_cq          interrupt levels from the command queue (rising edge = event)
//   cfg_en                  coalescer enable
//   cfg_thresh              events per interrupt
//   cfg_timeout             cycles from first pending event to forced fire
//   irq_req, irq_ack        request held until acknowledged
//   irq_vec                 0 = SQ, 1 = CQ
//   irq_evt_cnt             events folded into the current request
//   stat_clr, stat_sq_cnt, stat_cq_cnt   acked-request counters (CMD_QUEUE_IRQ_STATS_EN only)
//
// Build option: define CMD_QUEUE_IRQ_STATS_EN to add the statistics counters.

module cmd_queue_irq_coalesce #(
   parameter int C_CNT_WIDTH = 8,
   parameter int C_TMR_WIDTH = 16
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   irq_sq,
   input  logic                   irq_cq,
   input  logic                   cfg_en,
   input  logic [C_CNT_WIDTH-1:0] cfg_thresh,
   input  logic [C_TMR_WIDTH-1:0] cfg_timeout,
   output logic                   irq_req,
   output logic                   irq_vec,
   output logic [C_CNT_WIDTH-1:0] irq_evt_cnt,
   input  logic                   irq_ack
`ifdef CMD_QUEUE_IRQ_STATS_EN
   ,
   input  logic                   stat_clr,
   output logic [31:0]            stat_sq_cnt,
   output logic [31:0]            stat_cq_cnt
`endif
);

   localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);
   localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [C_TMR_WIDTH-1:0] TMR_ONE = C_TMR_WIDTH'(1);
   localparam logic [C_TMR_WIDTH-1:0] TMR_MAX = '1;

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t                 state, state_nxt;
   logic [1:0]             irq_in;     // index 0 = SQ, 1 = CQ
   logic [1:0]             prev;
   logic [1:0]             evt;
   logic [1:0]             fire;
   logic [1:0]             grant_oh;
   logic                   last_src;   // last granted source, drives round-robin
   logic [C_CNT_WIDTH-1:0] pend [2];
   logic [C_TMR_WIDTH-1:0] tmr  [2];
   logic [C_CNT_WIDTH-1:0] thresh_eff;

   assign irq_in     = {irq_cq, irq_sq};
   assign thresh_eff = (cfg_thresh == '0) ? CNT_ONE : cfg_thresh;
   assign irq_req    = (state == S_REQ);

   always_comb begin
      evt  = '0;
      fire = '0;
      for (int i = 0; i < 2; i++) begin
         evt[i]  = cfg_en & irq_in[i] & ~prev[i];
         fire[i] = (pend[i] != '0) &&
                   ((pend[i] >= thresh_eff) ||
                    ((cfg_timeout != '0) && (tmr[i] >= cfg_timeout)));
      end
   end

   // Next-state / grant selection
   always_comb begin
      state_nxt = state;
      grant_oh  = '0;
      case (state)
         S_IDLE: begin
            if (cfg_en && (fire != '0)) begin
               state_nxt = S_REQ;
               if (fire == 2'b11)
                  grant_oh = last_src ? 2'b01 : 2'b10;
               else
                  grant_oh = fire;
            end
         end
         S_REQ: begin
            if (irq_ack)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= S_IDLE;
         irq_vec     <= 1'b0;
         irq_evt_cnt <= '0;
         last_src    <= 1'b1;   // so the first contested grant goes to SQ
      end else begin
         state <= state_nxt;
         if (grant_oh != '0) begin
            irq_vec     <= grant_oh[1];
            last_src    <= grant_oh[1];
            irq_evt_cnt <= grant_oh[1] ? pend[1] : pend[0];
         end
      end
   end

   // Per-source edge detect, pending counter and timeout timer
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         prev <= '0;
         for (int i = 0; i < 2; i++) begin
            pend[i] <= '0;
            tmr[i]  <= '0;
         end
      end else begin
         prev <= irq_in;
         for (int i = 0; i < 2; i++) begin
            if (grant_oh[i]) begin
               // an event landing on the grant edge starts the next batch
               pend[i] <= evt[i] ? CNT_ONE : '0;
               tmr[i]  <= '0;
            end else if (!cfg_en) begin
               pend[i] <= '0;
               tmr[i]  <= '0;
            end else begin
               if (evt[i] && (pend[i] != CNT_MAX))
                  pend[i] <= pend[i] + CNT_ONE;
               if (pend[i] == '0)
                  tmr[i] <= '0;
               else if (tmr[i] != TMR_MAX)
                  tmr[i] <= tmr[i] + TMR_ONE;
            end
         end
      end
   end

`ifdef CMD_QUEUE_IRQ_STATS_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         stat_sq_cnt <= '0;
         stat_cq_cnt <= '0;
      end else if (stat_clr) begin
         stat_sq_cnt <= '0;
         stat_cq_cnt <= '0;
      end else if ((state == S_REQ) && irq_ack) begin
         if (!irq_vec && (stat_sq_cnt != 32'hFFFF_FFFF))
            stat_sq_cnt <= stat_sq_cnt + 32'd1;
         if (irq_vec && (stat_cq_cnt != 32'hFFFF_FFFF))
            stat_cq_cnt <= stat_cq_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cmd_queue_irq_coalesce.sv
// tb/tb_cmd_queue_irq_coalesce.sv - self-checking bench for cmd_queue_irq_coalesce

module tb_cmd_queue_irq_coalesce;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        irq_sq = 1'b0;
   logic        irq_cq = 1'b0;
   logic        cfg_en = 1'b1;
   logic [7:0]  cfg_thresh = 8'd1;
   logic [15:0] cfg_timeout = 16'd0;
   logic        irq_req;
   logic        irq_vec;
   logic [7:0]  irq_evt_cnt;
   logic        irq_ack = 1'b0;
   logic        stat_clr = 1'b0;
`ifdef CMD_QUEUE_IRQ_STATS_EN
   logic [31:0] stat_sq_cnt;
   logic [31:0] stat_cq_cnt;
`endif

   int checks = 0;
   int failures = 0;

   always #5 aclk = ~aclk;

   cmd_queue_irq_coalesce #(.C_CNT_WIDTH(8), .C_TMR_WIDTH(16)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .irq_sq      (irq_sq),
      .irq_cq      (irq_cq),
      .cfg_en      (cfg_en),
      .cfg_thresh  (cfg_thresh),
      .cfg_timeout (cfg_timeout),
      .irq_req     (irq_req),
      .irq_vec     (irq_vec),
      .irq_evt_cnt (irq_evt_cnt),
      .irq_ack     (irq_ack)
`ifdef CMD_QUEUE_IRQ_STATS_EN
      ,
      .stat_clr    (stat_clr),
      .stat_sq_cnt (stat_sq_cnt),
      .stat_cq_cnt (stat_cq_cnt)
`endif
   );

   // Reference model: integer counts of pending events and elapsed cycles per source,
   // one outstanding request, round-robin on contention.
   int    m_pend [2];
   int    m_tmr  [2];
   bit    m_prev [2];
   bit    m_req;
   int    m_vec;
   int    m_cnt;
   int    m_last;
   longint m_stat [2];

   always @(posedge aclk or negedge aresetn) begin : ref_model
      bit ev [2];
      bit fire [2];
      bit lvl [2];
      int th;
      int grant;
      if (!aresetn) begin
         for (int i = 0; i < 2; i++) begin
            m_pend[i] <= 0;
            m_tmr[i]  <= 0;
            m_prev[i] <= 1'b0;
            m_stat[i] <= 0;
         end
         m_req  <= 1'b0;
         m_vec  <= 0;
         m_cnt  <= 0;
         m_last <= 1;
      end else begin
         lvl[0] = irq_sq;
         lvl[1] = irq_cq;
         th = (cfg_thresh == 0) ? 1 : int'(cfg_thresh);
         grant = -1;
         for (int i = 0; i < 2; i++) begin
            ev[i]   = cfg_en && lvl[i] && !m_prev[i];
            fire[i] = (m_pend[i] > 0) &&
                      (m_pend[i] >= th || (cfg_timeout != 0 && m_tmr[i] >= int'(cfg_timeout)));
         end
         if (m_req) begin
            if (irq_ack) m_req <= 1'b0;
         end else if (cfg_en && (fire[0] || fire[1])) begin
            grant = (fire[0] && fire[1]) ? 1 - m_last : (fire[0] ? 0 : 1);
            m_req  <= 1'b1;
            m_vec  <= grant;
            m_last <= grant;
            m_cnt  <= m_pend[grant];
         end
         for (int i = 0; i < 2; i++) begin
            if (stat_clr) m_stat[i] <= 0;
            else if (m_req && irq_ack && m_vec == i && m_stat[i] < 64'hFFFF_FFFF)
               m_stat[i] <= m_stat[i] + 1;
            if (grant == i) begin
               m_pend[i] <= ev[i] ? 1 : 0;
               m_tmr[i]  <= 0;
            end else if (!cfg_en) begin
               m_pend[i] <= 0;
               m_tmr[i]  <= 0;
            end else begin
               m_tmr[i]  <= (m_pend[i] == 0) ? 0 : ((m_tmr[i] >= 65535) ? 65535 : m_tmr[i] + 1);
               m_pend[i] <= ev[i] ? ((m_pend[i] >= 255) ? 255 : m_pend[i] + 1) : m_pend[i];
            end
            m_prev[i] <= lvl[i];
         end
      end
   end

   task automatic cyc();
      @(posedge aclk);
      @(negedge aclk);
   endtask

   task automatic do_reset();
      @(negedge aclk);
      aresetn = 1'b0;
      irq_sq = 1'b0; irq_cq = 1'b0; irq_ack = 1'b0; stat_clr = 1'b0;
      cyc();
      cyc();
      aresetn = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      @(negedge aclk);
      aresetn = 1'b0;
      #1;
      checks++;
      if (irq_req !== 1'b0 || irq_vec !== 1'b0 || irq_evt_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset_outputs: req=%b vec=%b cnt=%0d required 0/0/0", irq_req, irq_vec, irq_evt_cnt);
      end
      cyc();
      aresetn = 1'b1;
      cyc();
      checks++;
      if (irq_req !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: req=%b required 0", irq_req);
      end
   endtask

   task automatic test_single_sq();
      cfg_en = 1'b1; cfg_thresh = 8'd1; cfg_timeout = 16'd0;
      irq_sq = 1'b1;
      cyc();
      checks++;
      if (irq_req !== 1'b0) begin
         failures++;
         $display("FAIL single_latency_early: req=%b required 0", irq_req);
      end
      irq_sq = 1'b0;
      cyc();
      checks++;
      if (irq_req !== 1'b1 || irq_vec !== 1'b0 || irq_evt_cnt !== 8'd1) begin
         failures++;
         $display("FAIL single_grant: req=%b vec=%b cnt=%0d required 1/0/1", irq_req, irq_vec, irq_evt_cnt);
      end
      cyc(); cyc();
      checks++;
      if (irq_req !== 1'b1) begin
         failures++;
         $display("FAIL single_hold: req=%b required 1", irq_req);
      end
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      checks++;
      if (irq_req !== 1'b0) begin
         failures++;
         $display("FAIL single_ack: req=%b required 0", irq_req);
      end
      cyc();
   endtask

   task automatic test_thresh_cq();
      cfg_thresh = 8'd4;
      for (int n = 0; n < 3; n++) begin
         irq_cq = 1'b1; cyc();
         irq_cq = 1'b0; cyc();
      end
      checks++;
      if (irq_req !== 1'b0) begin
         failures++;
         $display("FAIL thresh_below: req=%b required 0", irq_req);
      end
      irq_cq = 1'b1; cyc();
      irq_cq = 1'b0; cyc();
      checks++;
      if (irq_req !== 1'b1 || irq_vec !== 1'b1 || irq_evt_cnt !== 8'd4) begin
         failures++;
         $display("FAIL thresh_grant: req=%b vec=%b cnt=%0d required 1/1/4", irq_req, irq_vec, irq_evt_cnt);
      end
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0; cyc();
   endtask

   task automatic test_timeout();
      int early;
      cfg_thresh = 8'd8; cfg_timeout = 16'd20;
      early = 0;
      irq_sq = 1'b1; cyc();
      irq_sq = 1'b0;
      for (int n = 0; n < 20; n++) begin
         cyc();
         if (irq_req !== 1'b0) early++;
      end
      checks++;
      if (early != 0) begin
         failures++;
         $display("FAIL timeout_early: early_req_cycles=%0d required 0", early);
      end
      cyc();
      checks++;
      if (irq_req !== 1'b1 || irq_vec !== 1'b0 || irq_evt_cnt !== 8'd1) begin
         failures++;
         $display("FAIL timeout_grant: req=%b vec=%b cnt=%0d required 1/0/1", irq_req, irq_vec, irq_evt_cnt);
      end
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0; cyc();
      cfg_timeout = 16'd0;
   endtask

   task automatic test_round_robin();
      logic exp_vec;
      do_reset();
      cfg_thresh = 8'd1;
      irq_sq = 1'b1; irq_cq = 1'b1; cyc();
      irq_sq = 1'b0; irq_cq = 1'b0; cyc();
      checks++;
      if (irq_req !== 1'b1 || irq_vec !== 1'b0 || irq_evt_cnt !== 8'd1) begin
         failures++;
         $display("FAIL rr_first: req=%b vec=%b cnt=%0d required 1/0/1", irq_req, irq_vec, irq_evt_cnt);
      end
      exp_vec = 1'b1;
      for (int n = 0; n < 4; n++) begin
         irq_sq = 1'b1; irq_cq = 1'b1; cyc();
         irq_sq = 1'b0; irq_cq = 1'b0; cyc();
         irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
         checks++;
         if (irq_req !== 1'b0) begin
            failures++;
            $display("FAIL rr_gap_%0d: req=%b required 0", n, irq_req);
         end
         cyc();
         checks++;
         if (irq_req !== 1'b1 || irq_vec !== exp_vec || irq_evt_cnt !== 8'd2) begin
            failures++;
            $display("FAIL rr_grant_%0d: req=%b vec=%b cnt=%0d required 1/%b/2", n, irq_req, irq_vec, irq_evt_cnt, exp_vec);
         end
         exp_vec = ~exp_vec;
      end
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0; cyc();
   endtask

   task automatic test_saturation();
      do_reset();
      cfg_thresh = 8'd1;
      irq_sq = 1'b1; cyc(); irq_sq = 1'b0; cyc();
      for (int n = 0; n < 300; n++) begin
         irq_cq = 1'b1; cyc();
         irq_cq = 1'b0; cyc();
      end
      checks++;
      if (irq_req !== 1'b1 || irq_vec !== 1'b0) begin
         failures++;
         $display("FAIL sat_hold: req=%b vec=%b required 1/0", irq_req, irq_vec);
      end
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
      irq_cq = 1'b1; cyc(); irq_cq = 1'b0;
      checks++;
      if (irq_req !== 1'b1 || irq_vec !== 1'b1 || irq_evt_cnt !== 8'd255) begin
         failures++;
         $display("FAIL sat_grant: req=%b vec=%b cnt=%0d required 1/1/255", irq_req, irq_vec, irq_evt_cnt);
      end
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0; cyc();
      checks++;
      if (irq_req !== 1'b1 || irq_vec !== 1'b1 || irq_evt_cnt !== 8'd1) begin
         failures++;
         $display("FAIL sat_grant_edge_event: req=%b vec=%b cnt=%0d required 1/1/1", irq_req, irq_vec, irq_evt_cnt);
      end
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0; cyc();
   endtask

   task automatic test_async_reset();
      int stray;
      do_reset();
      cfg_thresh = 8'd1;
      irq_sq = 1'b1; cyc(); irq_sq = 1'b0; cyc();
      irq_cq = 1'b1; cyc(); irq_cq = 1'b0;
      #2;
      aresetn = 1'b0;
      #1;
      checks++;
      if (irq_req !== 1'b0) begin
         failures++;
         $display("FAIL async_reset_drop: req=%b required 0", irq_req);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      stray = 0;
      for (int n = 0; n < 4; n++) begin
         cyc();
         if (irq_req !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("FAIL async_reset_lost_events: req_cycles=%0d required 0", stray);
      end
   endtask

   task automatic test_disable();
      do_reset();
      cfg_thresh = 8'd1;
      irq_sq = 1'b1; cyc(); irq_sq = 1'b0; cyc();
      cfg_en = 1'b0;
      irq_cq = 1'b1; cyc(); irq_cq = 1'b0; cyc();
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
      cyc(); cyc();
      checks++;
      if (irq_req !== 1'b0) begin
         failures++;
         $display("FAIL disable_no_grant: req=%b required 0", irq_req);
      end
      cfg_en = 1'b1;
      cyc(); cyc();
      checks++;
      if (irq_req !== 1'b0) begin
         failures++;
         $display("FAIL disable_events_dropped: req=%b required 0", irq_req);
      end
   endtask

`ifdef CMD_QUEUE_IRQ_STATS_EN
   task automatic test_stats();
      do_reset();
      cfg_en = 1'b1; cfg_thresh = 8'd1; cfg_timeout = 16'd0;
      for (int n = 0; n < 3; n++) begin
         if (n < 2) irq_sq = 1'b1; else irq_cq = 1'b1;
         cyc();
         irq_sq = 1'b0; irq_cq = 1'b0;
         cyc();
         irq_ack = 1'b1; cyc(); irq_ack = 1'b0; cyc();
      end
      checks++;
      if (stat_sq_cnt !== 32'd2 || stat_cq_cnt !== 32'd1) begin
         failures++;
         $display("FAIL stats_count: sq=%0d cq=%0d required 2/1", stat_sq_cnt, stat_cq_cnt);
      end
      irq_sq = 1'b1; cyc(); irq_sq = 1'b0; cyc();
      irq_ack = 1'b1; stat_clr = 1'b1; cyc();
      irq_ack = 1'b0; stat_clr = 1'b0;
      checks++;
      if (stat_sq_cnt !== 32'd0 || stat_cq_cnt !== 32'd0 || irq_req !== 1'b0) begin
         failures++;
         $display("FAIL stats_clear_wins: sq=%0d cq=%0d req=%b required 0/0/0", stat_sq_cnt, stat_cq_cnt, irq_req);
      end
   endtask
`endif

   task automatic test_random();
      int bad;
      int thr_opts [4];
      do_reset();
      thr_opts[0] = 0; thr_opts[1] = 1; thr_opts[2] = 3; thr_opts[3] = 6;
      bad = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 400 == 0) begin
            cfg_thresh  = 8'(thr_opts[$urandom_range(0, 3)]);
            cfg_timeout = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(2, 25));
         end
         if (n % 250 == 0) cfg_en = ($urandom_range(0, 4) != 0);
         irq_sq   = ($urandom_range(0, 2) == 0) ? ~irq_sq : irq_sq;
         irq_cq   = ($urandom_range(0, 3) == 0) ? ~irq_cq : irq_cq;
         irq_ack  = ($urandom_range(0, 2) == 0);
         stat_clr = ($urandom_range(0, 99) == 0);
         cyc();
         checks++;
         if (irq_req !== m_req || (m_req && (irq_vec !== m_vec[0] || irq_evt_cnt !== 8'(m_cnt)))) begin
            failures++;
            bad++;
            if (bad <= 10)
               $display("FAIL random_cycle_%0d: req=%b vec=%b cnt=%0d required %b/%0d/%0d",
                        n, irq_req, irq_vec, irq_evt_cnt, m_req, m_vec, m_cnt);
         end
`ifdef CMD_QUEUE_IRQ_STATS_EN
         checks++;
         if (stat_sq_cnt !== 32'(m_stat[0]) || stat_cq_cnt !== 32'(m_stat[1])) begin
            failures++;
            $display("FAIL random_stats_%0d: sq=%0d cq=%0d required %0d/%0d",
                     n, stat_sq_cnt, stat_cq_cnt, m_stat[0], m_stat[1]);
         end
`endif
      end
      irq_ack = 1'b0; stat_clr = 1'b0; cfg_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_sq();
      test_thresh_cq();
      test_timeout();
      test_round_robin();
      test_saturation();
      test_async_reset();
      test_disable();
`ifdef CMD_QUEUE_IRQ_STATS_EN
      test_stats();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
